period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the half-period of a slow square wave, such as the toggling output of the team's programmable frequency divider.
- Reports the measurement as the equivalent divider limit: a wave toggling every L+1 clk cycles measures as L.
- Used for self-check of the divider chain and for inferring the rate of external clock-like inputs on the lab board.

Parameters:
- COUNT_W, 28, width of the interval counter and of meas; matches the divider limit width.

Ports:
- clk  input  1  global clock.
- rst  input  1  reset; asynchronous, active-high.
- signal_in  input  1  square wave to measure; may be asynchronous to clk.
- meas  output  COUNT_W  last measured half-period minus 1 (the equivalent divider limit).
- meas_valid  output  1  one-cycle pulse when meas is updated.
- locked  output  1  high when the last two consecutive measurements were equal.
- timeout  output  1  sticky; no edge was seen for 2^COUNT_W cycles.

Behaviour:
- Reset: one clock, asynchronous active-high reset. While rst=1:
  - meas=0, meas_valid=0, locked=0, timeout=0.
  - state=WAIT, cnt=0, previous-measurement register=0, sampling flops=0.
- Input path:
  - signal_in is sampled into sig_s.
  - sig_d is sig_s delayed by one cycle.
  - edge = sig_s XOR sig_d. Both rising and falling edges count.
- Counter cnt (COUNT_W bits):
  - Loads 0 on any edge cycle.
  - Otherwise increments each cycle and saturates at all-ones.
  - At the next edge, cnt equals the interval minus 1.
- State WAIT (after reset or timeout):
  - The first edge clears cnt and moves to MEASURE.
  - No meas_valid is produced, because the first interval is partial.
  - timeout clears on this edge.
- State MEASURE, on an edge:
  - meas <= cnt and meas_valid=1 for one cycle, registered on the next clk edge.
  - locked <= (cnt == previous measurement); the previous-measurement register then takes cnt.
- State MEASURE, no edge and cnt == all-ones:
  - timeout <= 1, locked <= 0, state -> WAIT.
  - meas keeps its last value; cnt holds saturated.
- Simultaneous events:
  - Edge in the same cycle that cnt is all-ones: the edge wins. meas = 2^COUNT_W-1 is reported, no timeout.
  - Edge every cycle (L=0): meas=0 on every cycle, meas_valid held high continuously, which is legal.
- Latency: count from the clk edge k that first captures the new signal_in level.
  - meas_valid and meas are visible after edge k+1, or k+2 with the synchronizer.
- Reset mid-operation: everything is cleared immediately; the first edge after release only arms the measurement.
- locked is never asserted before two valid measurements have been made since the last reset or timeout.

Optional Feature:
- Macro: PERIOD_METER_SYNC_EN.
- Defined: signal_in passes through a 2-flop synchronizer before sig_s. This adds 1 cycle of latency (valid after edge k+2) and makes the block safe for asynchronous inputs.
- Undefined: signal_in is registered directly into sig_s. Valid appears after edge k+1, and signal_in must be synchronous to clk.
- Measured values are identical in both builds.

Decomposition:
- Package period_meter_pkg holds:
  - state encoding constants ST_WAIT=1'b0 and ST_MEASURE=1'b1;
  - the default COUNT_W=28;
  - the derived constant CNT_MAX (all-ones).
- One sub-module, edge_sync:
  - contains the optional synchronizer, the sig_s/sig_d flops and the edge output;
  - has its own clk, rst and `ifdef PERIOD_METER_SYNC_EN.
- The top level holds the counter, the FSM and the output registers.

Test Plan:
1. Drive signal_in from the divider with limit=4 (toggle every 5 clk) -> the first edge gives no valid; then meas=4 with meas_valid every 5 cycles; locked=1 from the second valid onward; timeout=0.
2. limit=0 (toggle every clk) -> meas=0, meas_valid stays high continuously, locked=1 after two measurements.
3. Switch limit 4->9 mid-stream -> one transitional valid (value 4..9 depending on phase) drops locked=0; then meas=9 twice; locked=1 again.
4. COUNT_W=4, stop toggling -> 16 cycles after the last edge timeout=1 and locked=0. Restart toggling every 3 clk: the first edge clears timeout with no valid; the next edge gives meas=2, meas_valid=1.
5. Assert rst asynchronously between clk edges during measurement -> all outputs go to 0 without waiting for clk. After release, the first edge gives no valid and the second edge gives the correct meas.
6. Build with and without PERIOD_METER_SYNC_EN using the same stimulus -> identical meas sequence; meas_valid is delayed by exactly 1 cycle in the SYNC_EN build.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared constants and state encoding for period_meter and its edge front end.
package period_meter_pkg;

  // Default interval counter width; matches the divider limit width.
  localparam int COUNT_W_DEFAULT = 28;

  // Saturation value of the interval counter at the default width.
  localparam logic [COUNT_W_DEFAULT-1:0] CNT_MAX = '1;

  // Measurement FSM states.
  typedef enum logic {
    ST_WAIT    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/period_meter_edge_sync.sv
// edge_sync: samples signal_in and flags every level change (rising or falling).
// With PERIOD_METER_SYNC_EN defined, a metastability flop sits in front of
// sig_s, so sig_s/meta form a 2-flop synchronizer (one extra cycle of latency).
// Without it, signal_in must already be synchronous to clk.
module edge_sync
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic edge_pulse
);

  logic sig_s_q;
  logic sig_s_d;
  logic sig_d_q;
  logic sig_d_d;

`ifdef PERIOD_METER_SYNC_EN
  logic meta_q;
  logic meta_d;

  // Next-state for the synchronizer chain: signal_in -> meta -> sig_s -> sig_d.
  always_comb begin
    meta_d  = signal_in;
    sig_s_d = meta_q;
    sig_d_d = sig_s_q;
  end

  // First synchronizer stage; may go metastable, only ever feeds sig_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
    end
  end
`else
  // Next-state for the direct sampling path: signal_in -> sig_s -> sig_d.
  always_comb begin
    sig_s_d = signal_in;
    sig_d_d = sig_s_q;
  end
`endif

  // Sampled level and its one-cycle-delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_s_q <= 1'b0;
      sig_d_q <= 1'b0;
    end else begin
      sig_s_q <= sig_s_d;
      sig_d_q <= sig_d_d;
    end
  end

  assign edge_pulse = sig_s_q ^ sig_d_q;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the half-period of a slow square wave and reports it
// as the equivalent divider limit (toggle every L+1 cycles -> meas = L).
// Optional build macro PERIOD_METER_SYNC_EN adds a 2-flop input synchronizer
// in edge_sync (one cycle more latency, identical measured values).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signal_in,
  output logic [COUNT_W-1:0] meas,
  output logic               meas_valid,
  output logic               locked,
  output logic               timeout
);

  localparam logic [COUNT_W-1:0] CNT_TOP = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic edge_pulse;

  state_t             state_q,      state_d;
  logic [COUNT_W-1:0] cnt_q,        cnt_d;
  logic [COUNT_W-1:0] meas_q,       meas_d;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q,     locked_d;
  logic               timeout_q,    timeout_d;
  logic [COUNT_W-1:0] prev_q,       prev_d;
  // Set once a first valid measurement exists to compare against, so that
  // locked cannot rise on the very first measurement (even when it is 0).
  logic               have_prev_q,  have_prev_d;

  edge_sync u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .edge_pulse (edge_pulse)
  );

  // Interval counter: restarts on every edge, otherwise counts up and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_pulse) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // FSM next-state and output register next values.
  always_comb begin
    state_d      = state_q;
    meas_d       = meas_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;

    unique case (state_q)
      ST_WAIT: begin
        // First edge only arms: the interval before it is partial.
        if (edge_pulse) begin
          state_d     = ST_MEASURE;
          timeout_d   = 1'b0;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        // An edge wins over saturation, so a full-range interval is reported.
        if (edge_pulse) begin
          meas_d       = cnt_q;
          meas_valid_d = 1'b1;
          locked_d     = have_prev_q && (cnt_q == prev_q);
          prev_d       = cnt_q;
          have_prev_d  = 1'b1;
        end else if (cnt_q == CNT_TOP) begin
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State, counter and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign meas       = meas_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed table-driven bench for period_meter at COUNT_W=4.
// Each row toggles signal_in after `gap` clocks; the measured interval is gap,
// so the expected meas is gap-1. A checker compares meas_valid every cycle.
module tb_period_meter;

  localparam int W = 4;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int         gap;
    bit         valid;
    logic [W-1:0] meas;
    bit         locked;
  } row_t;

  typedef struct {
    int         due;
    bit         valid;
    logic [W-1:0] meas;
    bit         locked;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         signal_in = 1'b0;
  logic [W-1:0] meas;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_tog = 0;
  bit   chk_en = 1'b0;
  exp_t exp_q[$];

  row_t seg_a[15];
  row_t seg_b[4];
  row_t seg_c[3];

  period_meter #(.COUNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .meas       (meas),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle checker: meas_valid must pulse exactly when a row's result is due.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("valid", {31'd0, meas_valid}, {31'd0, e.valid});
        check("timeout_clear", {31'd0, timeout}, 32'd0);
        if (e.valid) begin
          check("meas", {28'd0, meas}, {28'd0, e.meas});
          check("locked", {31'd0, locked}, {31'd0, e.locked});
        end
        $display("cycle %0d: valid=%0d meas=%0d locked=%0d", cyc, meas_valid, meas, locked);
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        check("missed_due", cyc, e.due);
      end else begin
        check("idle_valid", {31'd0, meas_valid}, 32'd0);
      end
    end
  end

  task automatic apply_row(input row_t r);
    repeat (r.gap) @(posedge clk);
    #1 signal_in = ~signal_in;
    last_tog = cyc;
    exp_q.push_back('{due: cyc + LAT, valid: r.valid, meas: r.meas, locked: r.locked});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_meas"}, {28'd0, meas}, 32'd0);
    check({tag, "_valid"}, {31'd0, meas_valid}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    int target;

    // Limit 4, then limit 0 (edge every cycle), back to 4, then 9, then
    // full-range interval of 16 where the edge coincides with saturation.
    seg_a = '{
      '{3, 1'b0, 4'd0, 1'b0},
      '{5, 1'b1, 4'd4, 1'b0}, '{5, 1'b1, 4'd4, 1'b1}, '{5, 1'b1, 4'd4, 1'b1},
      '{1, 1'b1, 4'd0, 1'b0}, '{1, 1'b1, 4'd0, 1'b1}, '{1, 1'b1, 4'd0, 1'b1}, '{1, 1'b1, 4'd0, 1'b1},
      '{5, 1'b1, 4'd4, 1'b0}, '{5, 1'b1, 4'd4, 1'b1},
      '{10, 1'b1, 4'd9, 1'b0}, '{10, 1'b1, 4'd9, 1'b1}, '{10, 1'b1, 4'd9, 1'b1},
      '{16, 1'b1, 4'd15, 1'b0}, '{16, 1'b1, 4'd15, 1'b1}
    };
    // Restart after timeout: arming edge, then toggling every 3 clocks.
    seg_b = '{
      '{30, 1'b0, 4'd0, 1'b0},
      '{3, 1'b1, 4'd2, 1'b0}, '{3, 1'b1, 4'd2, 1'b1}, '{3, 1'b1, 4'd2, 1'b1}
    };
    // After a mid-run reset: arming edge, then limit 3.
    seg_c = '{
      '{2, 1'b0, 4'd0, 1'b0},
      '{4, 1'b1, 4'd3, 1'b0}, '{4, 1'b1, 4'd3, 1'b1}
    };

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #3 rst = 1'b0;
    chk_en = 1'b1;

    foreach (seg_a[i]) apply_row(seg_a[i]);

    // Stop toggling: timeout rises exactly 2^W cycles after the counter restarts.
    target = last_tog + LAT + 15;
    for (int n = 0; n < 200 && cyc < target; n++) @(negedge clk);
    check("timeout_early", {31'd0, timeout}, 32'd0);
    check("locked_before_to", {31'd0, locked}, 32'd1);
    @(negedge clk);
    check("timeout_set", {31'd0, timeout}, 32'd1);
    check("locked_after_to", {31'd0, locked}, 32'd0);
    check("meas_held", {28'd0, meas}, 32'd15);
    $display("cycle %0d: timeout=%0d locked=%0d meas=%0d", cyc, timeout, locked, meas);

    foreach (seg_b[i]) apply_row(seg_b[i]);

    // Asynchronous reset between clock edges while locked with meas=2.
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1 check_all_zero("async_rst");
    $display("cycle %0d: async reset meas=%0d locked=%0d", cyc, meas, locked);
    signal_in = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    foreach (seg_c[i]) apply_row(seg_c[i]);

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
